// File: rtl/panel_memory_sequencer.sv
// Front-panel memory sequencer: turns panel switch edges into single
// bus cycles under HOLD/HLDA, and keeps address/data latches and protect map.
module panel_memory_sequencer #(
    parameter int MEM_LATENCY = 2,
    parameter int PAGE_BITS   = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        examine,
    input  logic        examine_next,
    input  logic        deposit,
    input  logic        deposit_next,
    input  logic        reset_pb,
    input  logic        protect,
    input  logic        unprotect,
    input  logic [15:0] sw_addr,
    input  logic [7:0]  sw_data,
    output logic        cpu_hold,
    input  logic        cpu_hlda,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] addr_leds,
    output logic [7:0]  data_leds,
    output logic        prot_led,
    output logic        busy
);

    localparam int         NPAGE = 1 << PAGE_BITS;
    localparam logic [2:0] LAT   = 3'(MEM_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WRITE,
        S_READ,
        S_WAITRD
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       pc_q, pc_d;
    logic              pcld_q, pcld_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        data_q, data_d;
    logic              dep_q, dep_d;
    logic [NPAGE-1:0]  map_q, map_d;
    logic [6:0]        prev_q;
    logic [6:0]        sw_now;
    logic [6:0]        rise;
    logic [15:0]       addr_inc;
    logic [PAGE_BITS-1:0] page;

    // Bit order: 6 reset_pb, 5 protect, 4 unprotect, 3 deposit_next,
    // 2 deposit, 1 examine_next, 0 examine.
    assign sw_now = {reset_pb, protect, unprotect, deposit_next,
                     deposit, examine_next, examine};
    assign rise     = sw_now & ~prev_q;
    assign addr_inc = addr_q + 16'd1;
    assign page     = addr_q[15 -: PAGE_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        pcld_d  = 1'b0;
        wdata_d = wdata_q;
        data_d  = data_q;
        dep_d   = dep_q;
        map_d   = map_q;
        case (state_q)
            S_IDLE: begin
                if (rise[6]) begin
                    pcld_d = 1'b1;
                    pc_d   = 16'h0000;
                    addr_d = 16'h0000;
                end else if (!run) begin
                    if (rise[5]) begin
                        map_d[page] = 1'b1;
                    end else if (rise[4]) begin
                        map_d[page] = 1'b0;
                    end else if (rise[3]) begin
                        addr_d  = addr_inc;
                        wdata_d = sw_data;
                        dep_d   = 1'b1;
                        state_d = S_HOLD;
                    end else if (rise[2]) begin
                        wdata_d = sw_data;
                        dep_d   = 1'b1;
                        state_d = S_HOLD;
                    end else if (rise[1]) begin
                        addr_d  = addr_inc;
                        pc_d    = addr_inc;
                        pcld_d  = 1'b1;
                        dep_d   = 1'b0;
                        state_d = S_HOLD;
                    end else if (rise[0]) begin
                        addr_d  = sw_addr;
                        pc_d    = sw_addr;
                        pcld_d  = 1'b1;
                        dep_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cpu_hlda) begin
                    state_d = dep_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                state_d = S_READ;
            end
            S_READ: begin
                cnt_d   = 3'd1;
                state_d = S_WAITRD;
            end
            S_WAITRD: begin
                // Final wait cycle doubles as DONE: latch data and release bus.
                if (cnt_q == LAT) begin
                    data_d  = mem_rdata;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            pc_q    <= 16'h0000;
            pcld_q  <= 1'b0;
            wdata_q <= 8'h00;
            data_q  <= 8'h00;
            dep_q   <= 1'b0;
            map_q   <= '0;
            prev_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            pcld_q  <= pcld_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            dep_q   <= dep_d;
            map_q   <= map_d;
            prev_q  <= sw_now;
        end
    end

    assign cpu_hold  = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_we    = (state_q == S_WRITE) && !map_q[page];
    assign mem_re    = (state_q == S_READ);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign addr_leds = addr_q;
    assign data_leds = data_q;
    assign pc_value  = pc_q;
    assign pc_load   = pcld_q;
    assign prot_led  = map_q[page];

endmodule

// File: tb/tb_panel_memory_sequencer.sv
// Directed bench for panel_memory_sequencer with a latency-modelled memory
// and a CPU whose HLDA trails HOLD through a four-flop delay.
module tb_panel_memory_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [6:0]  cmd;
    logic [15:0] sw_addr;
    logic [7:0]  sw_data;
    logic        cpu_hold;
    logic        cpu_hlda;
    logic        pc_load;
    logic [15:0] pc_value;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [15:0] addr_leds;
    logic [7:0]  data_leds;
    logic        prot_led;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] C_RST = 7'b1000000;
    localparam logic [6:0] C_PRO = 7'b0100000;
    localparam logic [6:0] C_UNP = 7'b0010000;
    localparam logic [6:0] C_DPN = 7'b0001000;
    localparam logic [6:0] C_DEP = 7'b0000100;
    localparam logic [6:0] C_EXN = 7'b0000010;
    localparam logic [6:0] C_EXA = 7'b0000001;

    always #5 clk = ~clk;

    panel_memory_sequencer #(
        .MEM_LATENCY(LAT),
        .PAGE_BITS(6)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run(run),
        .examine(cmd[0]),
        .examine_next(cmd[1]),
        .deposit(cmd[2]),
        .deposit_next(cmd[3]),
        .reset_pb(cmd[6]),
        .protect(cmd[5]),
        .unprotect(cmd[4]),
        .sw_addr(sw_addr),
        .sw_data(sw_data),
        .cpu_hold(cpu_hold),
        .cpu_hlda(cpu_hlda),
        .pc_load(pc_load),
        .pc_value(pc_value),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .addr_leds(addr_leds),
        .data_leds(data_leds),
        .prot_led(prot_led),
        .busy(busy)
    );

    logic [7:0] mem [0:65535];
    logic [7:0] rpipe [LAT];
    logic [3:0] chain = 4'd0;
    int we_cnt = 0;
    int re_cnt = 0;
    int hold_rise = 0;
    logic hold_prev = 1'b0;

    assign cpu_hlda  = chain[3];
    assign mem_rdata = rpipe[LAT-1];

    always @(posedge clk) begin
        chain <= {chain[2:0], cpu_hold};
        rpipe[0] <= mem_re ? mem[mem_addr] : 8'hEE;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_cnt = we_cnt + 1;
        end
        if (mem_re) re_cnt = re_cnt + 1;
        if (cpu_hold && !hold_prev) hold_rise = hold_rise + 1;
        hold_prev = cpu_hold;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] m);
        cmd = m;
        step();
        cmd = 7'd0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s timeout: busy=%b required 0", nm, busy);
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run = 1'b0;
        cmd = 7'd0;
        sw_addr = 16'h0000;
        sw_data = 8'h00;
        repeat (3) step();
        total++;
        if ({cpu_hold, pc_load, mem_we, mem_re, busy, prot_led} !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctl got=%b required 000000",
                     {cpu_hold, pc_load, mem_we, mem_re, busy, prot_led});
        end
        total++;
        if ({mem_addr, mem_wdata, pc_value, addr_leds, data_leds} !== 64'd0) begin
            bad++;
            $display("FAIL reset_data addr=%h wd=%h pc=%h al=%h dl=%h required 0",
                     mem_addr, mem_wdata, pc_value, addr_leds, data_leds);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_examine();
        int re0;
        mem[16'h1234] = 8'hA5;
        sw_addr = 16'h1234;
        re0 = re_cnt;
        press(C_EXA);
        total++;
        if (addr_leds !== 16'h1234 || mem_addr !== 16'h1234 ||
            pc_load !== 1'b1 || pc_value !== 16'h1234 ||
            busy !== 1'b1 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL exa_c1 al=%h ma=%h ld=%b pc=%h busy=%b hold=%b required 1234 1234 1 1234 1 1",
                     addr_leds, mem_addr, pc_load, pc_value, busy, cpu_hold);
        end
        for (int c = 2; c <= 9; c++) begin
            step();
            if (c == 2) begin
                total++;
                if (pc_load !== 1'b0) begin
                    bad++;
                    $display("FAIL exa_pcpulse got=%b required 0", pc_load);
                end
            end
            if (c == 5) begin
                total++;
                if (mem_re !== 1'b0 || cpu_hlda !== 1'b1) begin
                    bad++;
                    $display("FAIL exa_c5 re=%b hlda=%b required 0 1", mem_re, cpu_hlda);
                end
            end
            if (c == 6) begin
                total++;
                if (mem_re !== 1'b1 || mem_we !== 1'b0) begin
                    bad++;
                    $display("FAIL exa_re6 re=%b we=%b required 1 0", mem_re, mem_we);
                end
            end
            if (c == 8) begin
                total++;
                if (cpu_hold !== 1'b1 || data_leds !== 8'h00) begin
                    bad++;
                    $display("FAIL exa_c8 hold=%b dl=%h required 1 00", cpu_hold, data_leds);
                end
            end
            if (c == 9) begin
                total++;
                if (data_leds !== 8'hA5 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL exa_c9 dl=%h hold=%b busy=%b required A5 0 0",
                             data_leds, cpu_hold, busy);
                end
            end
        end
        total++;
        if (re_cnt - re0 !== 1) begin
            bad++;
            $display("FAIL exa_recount got=%0d required 1", re_cnt - re0);
        end
        repeat (6) step();
    endtask

    task automatic test_deposit_wrap();
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'h00;
        sw_addr = 16'hFFFF;
        press(C_EXA);
        wait_done("dep_exa");
        sw_data = 8'h3C;
        press(C_DEP);
        total++;
        if (addr_leds !== 16'hFFFF || pc_load !== 1'b0) begin
            bad++;
            $display("FAIL dep_c1 al=%h ld=%b required FFFF 0", addr_leds, pc_load);
        end
        wait_done("dep");
        total++;
        if (mem[16'hFFFF] !== 8'h3C || data_leds !== 8'h3C) begin
            bad++;
            $display("FAIL dep_mem mem=%h dl=%h required 3C 3C", mem[16'hFFFF], data_leds);
        end
        press(C_DPN);
        total++;
        if (addr_leds !== 16'h0000 || mem_addr !== 16'h0000) begin
            bad++;
            $display("FAIL dpn_wrap al=%h ma=%h required 0000 0000", addr_leds, mem_addr);
        end
        wait_done("dpn");
        total++;
        if (mem[16'h0000] !== 8'h3C || data_leds !== 8'h3C || addr_leds !== 16'h0000) begin
            bad++;
            $display("FAIL dpn_mem mem=%h dl=%h al=%h required 3C 3C 0000",
                     mem[16'h0000], data_leds, addr_leds);
        end
    endtask

    task automatic test_protect();
        int we0;
        mem[16'h0400] = 8'h11;
        sw_addr = 16'h0400;
        press(C_EXA);
        wait_done("pro_exa");
        press(C_PRO);
        total++;
        if (prot_led !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL pro_led prot=%b busy=%b hold=%b required 1 0 0",
                     prot_led, busy, cpu_hold);
        end
        we0 = we_cnt;
        sw_data = 8'h77;
        press(C_DEP);
        wait_done("pro_dep");
        total++;
        if (we_cnt - we0 !== 0 || mem[16'h0400] !== 8'h11 || data_leds !== 8'h11) begin
            bad++;
            $display("FAIL pro_block we=%0d mem=%h dl=%h required 0 11 11",
                     we_cnt - we0, mem[16'h0400], data_leds);
        end
        press(C_UNP);
        total++;
        if (prot_led !== 1'b0) begin
            bad++;
            $display("FAIL unp_led got=%b required 0", prot_led);
        end
        we0 = we_cnt;
        press(C_DEP);
        wait_done("unp_dep");
        total++;
        if (we_cnt - we0 !== 1 || mem[16'h0400] !== 8'h77 || data_leds !== 8'h77) begin
            bad++;
            $display("FAIL unp_write we=%0d mem=%h dl=%h required 1 77 77",
                     we_cnt - we0, mem[16'h0400], data_leds);
        end
    endtask

    task automatic test_simultaneous();
        int h0, w0, r0;
        h0 = hold_rise;
        w0 = we_cnt;
        r0 = re_cnt;
        sw_addr = 16'h5555;
        sw_data = 8'h5A;
        press(C_DEP | C_EXA);
        total++;
        if (addr_leds !== 16'h0400 || pc_load !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL sim_c1 al=%h ld=%b busy=%b required 0400 0 1",
                     addr_leds, pc_load, busy);
        end
        step();
        press(C_EXA);
        wait_done("sim");
        total++;
        if (hold_rise - h0 !== 1 || we_cnt - w0 !== 1 || re_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL sim_counts hold=%0d we=%0d re=%0d required 1 1 1",
                     hold_rise - h0, we_cnt - w0, re_cnt - r0);
        end
        total++;
        if (mem[16'h0400] !== 8'h5A || addr_leds !== 16'h0400 ||
            data_leds !== 8'h5A || busy !== 1'b0) begin
            bad++;
            $display("FAIL sim_result mem=%h al=%h dl=%h busy=%b required 5A 0400 5A 0",
                     mem[16'h0400], addr_leds, data_leds, busy);
        end
    endtask

    task automatic test_run();
        int h0, w0, r0;
        run = 1'b1;
        h0 = hold_rise;
        w0 = we_cnt;
        r0 = re_cnt;
        sw_addr = 16'h2222;
        press(C_EXA);
        step();
        press(C_DEP);
        repeat (8) step();
        total++;
        if (hold_rise - h0 !== 0 || we_cnt - w0 !== 0 || re_cnt - r0 !== 0 ||
            addr_leds !== 16'h0400) begin
            bad++;
            $display("FAIL run_ignore hold=%0d we=%0d re=%0d al=%h required 0 0 0 0400",
                     hold_rise - h0, we_cnt - w0, re_cnt - r0, addr_leds);
        end
        press(C_RST);
        total++;
        if (pc_load !== 1'b1 || pc_value !== 16'h0000 || addr_leds !== 16'h0000 ||
            busy !== 1'b0) begin
            bad++;
            $display("FAIL run_rstpb ld=%b pc=%h al=%h busy=%b required 1 0000 0000 0",
                     pc_load, pc_value, addr_leds, busy);
        end
        repeat (4) step();
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int h0, w0, r0;
        sw_addr = 16'h1234;
        press(C_EXA);
        while (!mem_re && n < 30) begin
            step();
            n++;
        end
        total++;
        if (!mem_re) begin
            bad++;
            $display("FAIL mid_reach re=%b required 1", mem_re);
        end
        step();
        reset_n = 1'b0;
        step();
        total++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0 || data_leds !== 8'h00 ||
            addr_leds !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset hold=%b busy=%b dl=%h al=%h required 0 0 00 0000",
                     cpu_hold, busy, data_leds, addr_leds);
        end
        reset_n = 1'b1;
        h0 = hold_rise;
        w0 = we_cnt;
        r0 = re_cnt;
        repeat (10) step();
        total++;
        if (hold_rise - h0 !== 0 || we_cnt - w0 !== 0 || re_cnt - r0 !== 0 ||
            data_leds !== 8'h00) begin
            bad++;
            $display("FAIL mid_quiet hold=%0d we=%0d re=%0d dl=%h required 0 0 0 00",
                     hold_rise - h0, we_cnt - w0, re_cnt - r0, data_leds);
        end
    endtask

    initial begin
        test_reset();
        test_examine();
        test_deposit_wrap();
        test_protect();
        test_simultaneous();
        test_run();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
